// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: display scan-out reads take every RAM cycle they need, and the
// remaining cycles are shared round-robin between NumWr pixel writers via a req/gnt handshake.
module vga_fb_arbiter #(
  parameter int unsigned NumWr       = 2,
  parameter int unsigned AddrW       = 15,
  parameter int unsigned DataW       = 8,
  parameter int unsigned FbW         = 160,
  parameter int unsigned FbH         = 120,
  parameter int unsigned ScaleSh     = 2,
  parameter int unsigned WrBlankOnly = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pix_tick_i,
  input  logic [9:0]             pixel_x_i,
  input  logic [9:0]             pixel_y_i,
  input  logic                   de_i,
  input  logic [NumWr-1:0]       wr_req_i,
  input  logic [NumWr*AddrW-1:0] wr_addr_i,
  input  logic [NumWr*DataW-1:0] wr_data_i,
  output logic [NumWr-1:0]       wr_gnt_o,
  output logic                   ram_en_o,
  output logic                   ram_we_o,
  output logic [AddrW-1:0]       ram_addr_o,
  output logic [DataW-1:0]       ram_wdata_o,
  input  logic [DataW-1:0]       ram_rdata_i,
  output logic [DataW-1:0]       pix_data_o,
  output logic                   pix_valid_o,
  output logic                   err_addr_o
);

  localparam int unsigned PtrW   = (NumWr > 1) ? $clog2(NumWr) : 1;
  localparam int unsigned FbSize = FbW * FbH;

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [NumWr-1:0] wr_gnt_q, wr_gnt_d;
  logic             ram_en_q, ram_en_d;
  logic             ram_we_q, ram_we_d;
  logic [AddrW-1:0] ram_addr_q, ram_addr_d;
  logic [DataW-1:0] ram_wdata_q, ram_wdata_d;
  logic             err_q, err_d;
  logic             p1_valid_q, p1_de_q, p2_valid_q, p2_de_q;
  logic             pix_valid_q;
  logic [DataW-1:0] pix_data_q, pix_data_d;

  logic             rd_req;
  logic [31:0]      rd_lin;
  logic [NumWr-1:0] elig;
  logic [PtrW-1:0]  cand;
  logic [PtrW-1:0]  win_idx;
  logic             win_found;
  logic [AddrW-1:0] sel_addr;
  logic [DataW-1:0] sel_data;

  always_comb begin
    rd_req = pix_tick_i & de_i;
    rd_lin = 32'(pixel_y_i >> ScaleSh) * FbW + 32'(pixel_x_i >> ScaleSh);

    // A writer granted this cycle still shows its old request; mask it out.
    for (int i = 0; i < NumWr; i++) begin
      elig[i] = wr_req_i[i] & ~wr_gnt_q[i] & ((WrBlankOnly == 0) | ~de_i);
    end

    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = 0; k < NumWr; k++) begin
      cand = PtrW'((32'(ptr_q) + 32'(k)) % NumWr);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    sel_addr = wr_addr_i[32'(win_idx) * AddrW +: AddrW];
    sel_data = wr_data_i[32'(win_idx) * DataW +: DataW];
  end

  always_comb begin
    ptr_d       = ptr_q;
    wr_gnt_d    = '0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    err_d       = err_q;

    if (rd_req) begin
      ram_en_d   = 1'b1;
      ram_addr_d = rd_lin[AddrW-1:0];
    end else if (win_found) begin
      wr_gnt_d[win_idx] = 1'b1;
      if (32'(win_idx) == NumWr - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + PtrW'(1);
      end
      // Out-of-range writes are acknowledged but never reach the RAM.
      if (32'(sel_addr) >= FbSize) begin
        err_d = 1'b1;
      end else begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = sel_addr;
        ram_wdata_d = sel_data;
      end
    end
  end

  always_comb begin
    pix_data_d = pix_data_q;
    if (p2_valid_q) begin
      pix_data_d = p2_de_q ? ram_rdata_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q       <= '0;
      wr_gnt_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      err_q       <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_de_q     <= 1'b0;
      p2_valid_q  <= 1'b0;
      p2_de_q     <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      wr_gnt_q    <= wr_gnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      err_q       <= err_d;
      p1_valid_q  <= pix_tick_i;
      p1_de_q     <= de_i;
      p2_valid_q  <= p1_valid_q;
      p2_de_q     <= p1_de_q;
      pix_valid_q <= p2_valid_q;
      pix_data_q  <= pix_data_d;
    end
  end

  assign wr_gnt_o    = wr_gnt_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign pix_data_o  = pix_data_q;
  assign pix_valid_o = pix_valid_q;
  assign err_addr_o  = err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus a random run scored against a
// cycle-level behavioural model of the arbitration and display-latency rules.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_tick = 1'b0;
  logic [9:0]  px = '0, py = '0;
  logic        de = 1'b0;
  logic [1:0]  wr_req = '0;
  logic [29:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [7:0]  ram_rdata = '0;

  logic [1:0]  wr_gnt, b_wr_gnt;
  logic        ram_en, ram_we, b_ram_en, b_ram_we;
  logic [14:0] ram_addr, b_ram_addr;
  logic [7:0]  ram_wdata, b_ram_wdata, pix_data, b_pix_data;
  logic        pix_valid, b_pix_valid, err_addr, b_err_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk_i(clk), .reset_i(reset), .pix_tick_i(pix_tick), .pixel_x_i(px), .pixel_y_i(py),
    .de_i(de), .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_gnt_o(wr_gnt), .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .pix_data_o(pix_data),
    .pix_valid_o(pix_valid), .err_addr_o(err_addr)
  );

  vga_fb_arbiter #(.WrBlankOnly(1)) dut_b (
    .clk_i(clk), .reset_i(reset), .pix_tick_i(pix_tick), .pixel_x_i(px), .pixel_y_i(py),
    .de_i(de), .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_gnt_o(b_wr_gnt), .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(ram_rdata), .pix_data_o(b_pix_data),
    .pix_valid_o(b_pix_valid), .err_addr_o(b_err_addr)
  );

  // Behavioural model of the default-parameter instance.
  typedef struct {int due; bit de;} pend_t;
  pend_t       pq[$];
  int          cyc;
  int          m_ptr;
  logic [1:0]  m_gnt;
  logic        m_en, m_we, m_err, m_pv;
  logic [14:0] m_addr;
  logic [7:0]  m_wdata, m_pd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pq.delete();
      cyc <= 0; m_ptr <= 0; m_gnt <= '0; m_en <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_pv <= 1'b0; m_addr <= '0; m_wdata <= '0; m_pd <= '0;
    end else begin
      automatic int win = -1;
      automatic int wa;
      m_gnt <= '0; m_en <= 1'b0; m_we <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        automatic int j = (m_ptr + k) % 2;
        if (win < 0 && wr_req[j] && !m_gnt[j]) win = j;
      end
      if (pix_tick && de) begin
        m_en   <= 1'b1;
        m_addr <= 15'(((int'(py) / 4) * 160 + int'(px) / 4) % 32768);
      end else if (win >= 0) begin
        m_gnt <= 2'(1 << win);
        m_ptr <= (win + 1) % 2;
        wa = int'(wr_addr[win*15 +: 15]);
        if (wa >= 160 * 120) begin
          m_err <= 1'b1;
        end else begin
          m_en <= 1'b1; m_we <= 1'b1; m_addr <= 15'(wa); m_wdata <= wr_data[win*8 +: 8];
        end
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        m_pv <= 1'b1;
        m_pd <= pq[0].de ? ram_rdata : 8'h00;
        void'(pq.pop_front());
      end else begin
        m_pv <= 1'b0;
      end
      if (pix_tick) pq.push_back('{due: cyc + 2, de: de});
      cyc <= cyc + 1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pix_tick = 1'b0; de = 1'b0; wr_req = '0; ram_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({wr_gnt, ram_en, ram_we, ram_addr, ram_wdata, pix_data, pix_valid, err_addr} !== '0) begin
      errors++; $display("FAIL reset_init: outputs nonzero during reset");
    end
    reset = 1'b0; wr_req = 2'b11;
    wr_addr = {15'd222, 15'd111}; wr_data = {8'hB2, 8'hB1};
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b01) begin
      errors++; $display("FAIL reset_pre_gnt: got %b want 01", wr_gnt);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({wr_gnt, ram_en, ram_we, ram_addr, ram_wdata, pix_data, pix_valid, err_addr,
         b_wr_gnt, b_ram_en, b_ram_we, b_ram_addr} !== '0) begin
      errors++; $display("FAIL reset_mid_write: outputs nonzero during reset");
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b01 || ram_we !== 1'b1 || ram_addr !== 15'd111) begin
      errors++;
      $display("FAIL reset_first_gnt: got gnt %b we %b addr %0d want 01 1 111",
               wr_gnt, ram_we, ram_addr);
    end
    wr_req = '0;
  endtask

  task automatic test_display_read();
    do_reset();
    pix_tick = 1'b1; px = 10'd9; py = 10'd5; de = 1'b1;
    @(negedge clk);
    pix_tick = 1'b0;
    checks++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 15'd162) begin
      errors++;
      $display("FAIL rd_addr: got en %b we %b addr %0d want 1 0 162", ram_en, ram_we, ram_addr);
    end
    @(negedge clk);
    ram_rdata = 8'hA5;
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL rd_early_valid: got %b want 0", pix_valid);
    end
    @(negedge clk);
    ram_rdata = 8'h00;
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'hA5) begin
      errors++; $display("FAIL rd_data: got v %b d %h want 1 a5", pix_valid, pix_data);
    end
    pix_tick = 1'b1; de = 1'b0;
    @(negedge clk);
    pix_tick = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 8'hA5 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold: got v %b d %h en %b want 0 a5 0", pix_valid, pix_data, ram_en);
    end
    ram_rdata = 8'h3C;
    repeat (2) @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 8'h00) begin
      errors++; $display("FAIL rd_blank: got v %b d %h want 1 00", pix_valid, pix_data);
    end
    ram_rdata = 8'h00;
  endtask

  task automatic test_round_robin();
    do_reset();
    wr_addr = {15'd200, 15'd100}; wr_data = {8'h22, 8'h11}; wr_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (wr_gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10) || ram_we !== 1'b1 ||
          ram_addr !== ((k % 2 == 0) ? 15'd100 : 15'd200) ||
          ram_wdata !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin
        errors++;
        $display("FAIL rr_step%0d: got gnt %b addr %0d data %h", k, wr_gnt, ram_addr, ram_wdata);
      end
    end
    wr_req = '0;
  endtask

  task automatic test_display_priority();
    do_reset();
    wr_addr = {15'd0, 15'd77}; wr_data = {8'h00, 8'h5A};
    pix_tick = 1'b1; de = 1'b1; px = 10'd40; py = 10'd8; wr_req = 2'b01;
    @(negedge clk);
    pix_tick = 1'b0;
    checks++;
    if (wr_gnt !== 2'b00 || ram_we !== 1'b0 || ram_addr !== 15'd330) begin
      errors++;
      $display("FAIL prio_read: got gnt %b we %b addr %0d want 00 0 330", wr_gnt, ram_we, ram_addr);
    end
    @(negedge clk);
    checks++;
    if (wr_gnt !== 2'b01 || ram_we !== 1'b1 || ram_addr !== 15'd77 || ram_wdata !== 8'h5A) begin
      errors++;
      $display("FAIL prio_write: got gnt %b we %b addr %0d want 01 1 77", wr_gnt, ram_we, ram_addr);
    end
    wr_req = '0; de = 1'b0;
  endtask

  task automatic test_blank_only();
    do_reset();
    wr_addr = {15'd300, 15'd0}; wr_data = {8'h99, 8'h00};
    wr_req = 2'b10; de = 1'b1; pix_tick = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (b_wr_gnt !== 2'b00) begin
        errors++; $display("FAIL blank_hold%0d: got gnt %b want 00", c, b_wr_gnt);
      end
      pix_tick = (c % 4 == 0);
    end
    de = 1'b0; pix_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (b_wr_gnt !== 2'b10 || b_ram_we !== 1'b1 || b_ram_addr !== 15'd300) begin
      errors++;
      $display("FAIL blank_gnt: got gnt %b we %b addr %0d want 10 1 300",
               b_wr_gnt, b_ram_we, b_ram_addr);
    end
    wr_req = '0;
  endtask

  task automatic test_err_addr();
    do_reset();
    wr_addr = {15'd0, 15'd19200}; wr_data = {8'h00, 8'h77}; wr_req = 2'b01;
    @(negedge clk);
    wr_req = '0;
    checks++;
    if (wr_gnt !== 2'b01 || ram_en !== 1'b0 || err_addr !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got gnt %b en %b err %b want 01 0 1", wr_gnt, ram_en, err_addr);
    end
    repeat (3) @(negedge clk);
    wr_addr = {15'd0, 15'd19199}; wr_req = 2'b01;
    @(negedge clk);
    wr_req = '0;
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 15'd19199 || err_addr !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got en %b addr %0d err %b want 1 19199 1",
               ram_en, ram_addr, err_addr);
    end
    do_reset();
    checks++;
    if (err_addr !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (600) begin
      @(negedge clk);
      checks++;
      if (wr_gnt !== m_gnt || ram_en !== m_en || ram_we !== m_we) begin
        errors++;
        $display("FAIL rand_ctrl@%0t: got gnt %b en %b we %b want %b %b %b",
                 $time, wr_gnt, ram_en, ram_we, m_gnt, m_en, m_we);
      end
      checks++;
      if (ram_addr !== m_addr || ram_wdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_ram@%0t: got addr %0d data %h want %0d %h",
                 $time, ram_addr, ram_wdata, m_addr, m_wdata);
      end
      checks++;
      if (pix_valid !== m_pv || pix_data !== m_pd || err_addr !== m_err) begin
        errors++;
        $display("FAIL rand_pix@%0t: got v %b d %h err %b want %b %h %b",
                 $time, pix_valid, pix_data, err_addr, m_pv, m_pd, m_err);
      end
      pix_tick  = ($urandom % 3 == 0);
      de        = ($urandom % 4 != 0);
      px        = 10'($urandom % 640);
      py        = 10'($urandom % 480);
      ram_rdata = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (!wr_req[i] || m_gnt[i]) begin
          wr_req[i]           = 1'($urandom % 2);
          wr_addr[i*15 +: 15] = ($urandom % 16 == 0) ? 15'(19200 + $urandom % 100)
                                                     : 15'($urandom % 19200);
          wr_data[i*8 +: 8]   = 8'($urandom);
        end
      end
    end
    wr_req = '0; pix_tick = 1'b0; de = 1'b0;
  endtask

  initial begin
    test_reset();
    test_display_read();
    test_round_robin();
    test_display_priority();
    test_blank_only();
    test_err_addr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
